user_logic_signal_processing: RTL and testbench
===============================================

USER_LOGIC_SIGNAL_PROCESSING -- requirements
Module: user_logic_signal_processing

Interface
REQ-001 Parameter SEG_CLKS, default 512: clocks per capture segment (2 samples/clock, 1024 samples).
REQ-002 Parameter ACC_W, default 40: accumulator width per bin.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 x0_i, x0z_i  in  16 each  channel-0 samples, signed; x0_i earlier, x0z_i later in time.
REQ-006 x1_i, x1z_i  in  16 each  channel-1 samples, signed.
REQ-007 trigger_vector_i  in  4  trigger lines; bit 0 = acquisition trigger.
REQ-008 user_register_i  in  128  control: [7:0] N_ACC, pulses to accumulate (0 treated as 1); [40:32] readout bin address; other bits ignored.
REQ-009 y0_o, y0z_o, y1_o, y1z_o  out  16 each  registered copies of x0_i, x0z_i, x1_i, x1z_i.
REQ-010 trigger_vector_o  out  4  registered copy of trigger_vector_i.
REQ-011 user_register_o  out  64  status/readout: [63:32] bin data, [31:24] 0, [23:16] pulse count, [15:2] 0, [1] busy, [0] done.
REQ-012 ul_partnum_1_o/_2_o/_3_o/_rev_o  out  16 each  constants 16'h0214, 16'h5350, 16'h4543, 16'h0001.

Function
REQ-013 Pass-through outputs SHALL have exactly one clock latency.
REQ-014 Trigger event SHALL be rising edge of trigger_vector_i[0] (compared with its registered value); a 1-clock pulse counts.
REQ-015 Idle + trigger: busy=1 next clock, bin index k=0; k increments each clock to SEG_CLKS-1, then busy=0.
REQ-016 Triggers while busy SHALL be ignored (no count change, no restart).
REQ-017 Per capture clock: p = x0^2 + x0z^2, unsigned 32 bits (max 2^31, no overflow); pipeline: register samples, square, add, read-modify-write bin k.
REQ-018 First pulse of a run SHALL write p (overwrite); later pulses add p into the ACC_W-bit bin.
REQ-019 Pulse count increments when each segment's last write completes; at count==N_ACC: done=1, run ends.
REQ-020 New run starts at the next trigger after done, or at first trigger after reset: count=0, done=0, first-pulse mode.
REQ-021 Readout: bin addressed by user_register_i[40:32] SHALL appear on user_register_o[63:32] 2 clocks after address is stable; saturate to 32'hFFFFFFFF if bin > 2^32-1.
REQ-022 Readout SHALL use a second RAM port and be valid during capture (value may be mid-run).
REQ-023 N_ACC change during a run SHALL take effect at the next count comparison.

Reset
REQ-024 rst_i low: all outputs 0 except partnum constants; busy=0, done=0, count=0, k=0, pipeline valids cleared; RAM contents undefined and never read as valid before first write of a run.
REQ-025 Reset mid-capture SHALL abort the segment; after release, module idle awaiting trigger.

Structure
REQ-026 Shared package: SEG_CLKS, ACC_W, partnum constants, user_register bit-field positions.
REQ-027 One sub-module gate_power_accumulator (square/sum pipeline + dual-port bin RAM + count/done logic); top holds pass-through registers, trigger edge detect, register mapping.

Verification
REQ-028 Reset asserted -> all y*_o, trigger_vector_o, user_register_o = 0; partnums 0214/5350/4543/0001.
REQ-029 x0_i=16'h1234, x1z_i=16'h8000, trigger_vector_i=4'b1000 -> same values on outputs exactly 1 clock later.
REQ-030 x0=x0z=100, N_ACC=16, 16 triggers 600 clocks apart -> done=1, count=16, every bin reads 320000.
REQ-031 Second trigger 100 clocks after first, N_ACC=2 -> count stays 1 after first segment, done=0.
REQ-032 x0=x0z=-32768, N_ACC=255, 255 triggers -> bin read = 32'hFFFFFFFF (saturated).
REQ-033 Reset low for 1 clock at k=200 -> busy=0, done=0, count=0; next trigger restarts at k=0 and overwrites bins.

Source files
------------

// File: rtl/user_logic_signal_processing_pkg.sv
// Shared constants, register field positions and state encoding for the
// gated power accumulator user block.
package user_logic_signal_processing_pkg;

   localparam int SEG_CLKS_DEF = 512;
   localparam int ACC_W_DEF    = 40;

   localparam logic [15:0] PARTNUM_1   = 16'h0214;
   localparam logic [15:0] PARTNUM_2   = 16'h5350;
   localparam logic [15:0] PARTNUM_3   = 16'h4543;
   localparam logic [15:0] PARTNUM_REV = 16'h0001;

   // user_register_i control fields
   localparam int UR_NACC_LSB = 0;
   localparam int UR_NACC_W   = 8;
   localparam int UR_ADDR_LSB = 32;
   localparam int UR_ADDR_W   = 9;

   // user_register_o status fields
   localparam int ST_DONE_BIT  = 0;
   localparam int ST_BUSY_BIT  = 1;
   localparam int ST_COUNT_LSB = 16;
   localparam int ST_DATA_LSB  = 32;

   typedef enum logic [1:0] {
      GPA_IDLE    = 2'd0,
      GPA_CAPTURE = 2'd1,
      GPA_DRAIN   = 2'd2
   } gpa_state_t;

   // A programmed pulse count of zero behaves as a single pulse.
   function automatic logic [7:0] nacc_eff(input logic [7:0] n);
      return (n == 8'd0) ? 8'd1 : n;
   endfunction

endpackage

// File: rtl/user_logic_signal_processing_gate_power_accumulator.sv
// Square/sum pipeline feeding a dual-port bin RAM with read-modify-write
// accumulation, pulse counting and a saturating second readout port.
module gate_power_accumulator
   import user_logic_signal_processing_pkg::*;
#(
   parameter int SEG_CLKS = SEG_CLKS_DEF,
   parameter int ACC_W    = ACC_W_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 trig_i,
   input  logic signed [15:0]   x0_i,
   input  logic signed [15:0]   x0z_i,
   input  logic [7:0]           n_acc_i,
   input  logic [UR_ADDR_W-1:0] rd_addr_i,
   output logic [31:0]          rd_data_o,
   output logic [7:0]           count_o,
   output logic                 done_o,
   output gpa_state_t           state_o
);

   localparam int AW = (SEG_CLKS > 1) ? $clog2(SEG_CLKS) : 1;

   gpa_state_t r_state, w_next_state;
   logic             w_accept;
   logic [AW-1:0]    r_k;
   logic             w_last_k;
   logic             r_first, r_run, r_done;
   logic [7:0]       r_count;
   logic [8:0]       w_count_inc;

   logic             r_s1_valid, r_s1_last, r_s1_first;
   logic [AW-1:0]    r_s1_k;
   logic signed [15:0] r_s1_x0, r_s1_x0z;
   logic             r_s2_valid, r_s2_last, r_s2_first;
   logic [AW-1:0]    r_s2_k;
   logic [31:0]      r_s2_sq0, r_s2_sq1;
   logic             r_s3_valid, r_s3_last, r_s3_first;
   logic [AW-1:0]    r_s3_k;
   logic [31:0]      r_s3_p;
   logic [ACC_W-1:0] r_s3_old;

   logic signed [31:0] w_x0_ext, w_x0z_ext, w_sq0, w_sq1;
   logic [ACC_W-1:0] w_p_ext, w_wr_data;
   logic [ACC_W-1:0] r_mem [SEG_CLKS];
   logic [AW-1:0]    w_rd_addr;
   logic [ACC_W-1:0] r_rd_q;
   logic [31:0]      r_rd_data;

   assign w_last_k = (r_k == AW'(SEG_CLKS - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= GPA_IDLE;
      else        r_state <= w_next_state;
   end

   // The run waits in DRAIN until the segment's last bin write lands, so a
   // new segment can never race the previous one through the RMW path.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      unique case (r_state)
         GPA_IDLE: begin
            if (trig_i) begin
               w_next_state = GPA_CAPTURE;
               w_accept     = 1'b1;
            end
         end
         GPA_CAPTURE: if (w_last_k) w_next_state = GPA_DRAIN;
         GPA_DRAIN:   if (r_s3_valid && r_s3_last) w_next_state = GPA_IDLE;
         default:     w_next_state = GPA_IDLE;
      endcase
   end

   assign w_count_inc = {1'b0, r_count} + 9'd1;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_k     <= '0;
         r_first <= 1'b0;
         r_run   <= 1'b0;
         r_done  <= 1'b0;
         r_count <= 8'd0;
      end else begin
         if (w_accept) begin
            r_k <= '0;
            if (!r_run) begin
               r_run   <= 1'b1;
               r_first <= 1'b1;
               r_count <= 8'd0;
               r_done  <= 1'b0;
            end
         end else if (r_state == GPA_CAPTURE) begin
            r_k <= r_k + 1'b1;
            if (w_last_k) r_first <= 1'b0;
         end
         if (r_s3_valid && r_s3_last) begin
            r_count <= w_count_inc[7:0];
            if (w_count_inc >= {1'b0, nacc_eff(n_acc_i)}) begin
               r_done <= 1'b1;
               r_run  <= 1'b0;
            end
         end
      end
   end

   assign w_x0_ext  = {{16{r_s1_x0[15]}},  r_s1_x0};
   assign w_x0z_ext = {{16{r_s1_x0z[15]}}, r_s1_x0z};
   assign w_sq0     = w_x0_ext * w_x0_ext;
   assign w_sq1     = w_x0z_ext * w_x0z_ext;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_s1_valid <= 1'b0; r_s1_last <= 1'b0; r_s1_first <= 1'b0;
         r_s1_k     <= '0;   r_s1_x0   <= '0;   r_s1_x0z   <= '0;
         r_s2_valid <= 1'b0; r_s2_last <= 1'b0; r_s2_first <= 1'b0;
         r_s2_k     <= '0;   r_s2_sq0  <= '0;   r_s2_sq1   <= '0;
         r_s3_valid <= 1'b0; r_s3_last <= 1'b0; r_s3_first <= 1'b0;
         r_s3_k     <= '0;   r_s3_p    <= '0;
      end else begin
         r_s1_valid <= (r_state == GPA_CAPTURE);
         r_s1_last  <= w_last_k;
         r_s1_first <= r_first;
         r_s1_k     <= r_k;
         r_s1_x0    <= x0_i;
         r_s1_x0z   <= x0z_i;
         r_s2_valid <= r_s1_valid;
         r_s2_last  <= r_s1_last;
         r_s2_first <= r_s1_first;
         r_s2_k     <= r_s1_k;
         r_s2_sq0   <= w_sq0;
         r_s2_sq1   <= w_sq1;
         r_s3_valid <= r_s2_valid;
         r_s3_last  <= r_s2_last;
         r_s3_first <= r_s2_first;
         r_s3_k     <= r_s2_k;
         r_s3_p     <= r_s2_sq0 + r_s2_sq1;
      end
   end

   assign w_p_ext   = {{(ACC_W-32){1'b0}}, r_s3_p};
   assign w_wr_data = r_s3_first ? w_p_ext : (r_s3_old + w_p_ext);
   assign w_rd_addr = rd_addr_i[AW-1:0];

   // Port A: RMW read one stage ahead of its write; port B: user readout.
   always_ff @(posedge clk_i) begin
      r_s3_old <= r_mem[r_s2_k];
      r_rd_q   <= r_mem[w_rd_addr];
      if (r_s3_valid) r_mem[r_s3_k] <= w_wr_data;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                 r_rd_data <= 32'd0;
      else if (|r_rd_q[ACC_W-1:32]) r_rd_data <= 32'hFFFF_FFFF;
      else                        r_rd_data <= r_rd_q[31:0];
   end

   assign rd_data_o = r_rd_data;
   assign count_o   = r_count;
   assign done_o    = r_done;
   assign state_o   = r_state;

endmodule

// File: rtl/user_logic_signal_processing.sv
// User block top: one-clock pass-through, trigger edge detect and mapping of
// the control/status registers onto the gated power accumulator.
module user_logic_signal_processing
   import user_logic_signal_processing_pkg::*;
#(
   parameter int SEG_CLKS = SEG_CLKS_DEF,
   parameter int ACC_W    = ACC_W_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [15:0]   x0_i,
   input  logic [15:0]   x0z_i,
   input  logic [15:0]   x1_i,
   input  logic [15:0]   x1z_i,
   input  logic [3:0]    trigger_vector_i,
   input  logic [127:0]  user_register_i,
   output logic [15:0]   y0_o,
   output logic [15:0]   y0z_o,
   output logic [15:0]   y1_o,
   output logic [15:0]   y1z_o,
   output logic [3:0]    trigger_vector_o,
   output logic [63:0]   user_register_o,
   output logic [15:0]   ul_partnum_1_o,
   output logic [15:0]   ul_partnum_2_o,
   output logic [15:0]   ul_partnum_3_o,
   output logic [15:0]   ul_partnum_rev_o
);

   logic [15:0] r_y0, r_y0z, r_y1, r_y1z;
   logic [3:0]  r_trig_vec;
   logic        w_trig_edge;
   logic [31:0] w_rd_data;
   logic [7:0]  w_count;
   logic        w_done, w_busy;
   gpa_state_t  w_state;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_y0 <= '0; r_y0z <= '0; r_y1 <= '0; r_y1z <= '0;
         r_trig_vec <= '0;
      end else begin
         r_y0 <= x0_i; r_y0z <= x0z_i; r_y1 <= x1_i; r_y1z <= x1z_i;
         r_trig_vec <= trigger_vector_i;
      end
   end

   // The pass-through register doubles as the edge-detect history.
   assign w_trig_edge = trigger_vector_i[0] & ~r_trig_vec[0];

   gate_power_accumulator #(
      .SEG_CLKS (SEG_CLKS),
      .ACC_W    (ACC_W)
   ) u_gpa (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .trig_i    (w_trig_edge),
      .x0_i      (x0_i),
      .x0z_i     (x0z_i),
      .n_acc_i   (user_register_i[UR_NACC_LSB +: UR_NACC_W]),
      .rd_addr_i (user_register_i[UR_ADDR_LSB +: UR_ADDR_W]),
      .rd_data_o (w_rd_data),
      .count_o   (w_count),
      .done_o    (w_done),
      .state_o   (w_state)
   );

   assign w_busy = (w_state == GPA_CAPTURE);

   always_comb begin
      user_register_o = '0;
      user_register_o[ST_DATA_LSB +: 32] = w_rd_data;
      user_register_o[ST_COUNT_LSB +: 8] = w_count;
      user_register_o[ST_BUSY_BIT]       = w_busy;
      user_register_o[ST_DONE_BIT]       = w_done;
   end

   assign y0_o             = r_y0;
   assign y0z_o            = r_y0z;
   assign y1_o             = r_y1;
   assign y1z_o            = r_y1z;
   assign trigger_vector_o = r_trig_vec;
   assign ul_partnum_1_o   = PARTNUM_1;
   assign ul_partnum_2_o   = PARTNUM_2;
   assign ul_partnum_3_o   = PARTNUM_3;
   assign ul_partnum_rev_o = PARTNUM_REV;

endmodule

// File: tb/tb_user_logic_signal_processing.sv
// Directed bench for the gated power accumulator block with hand-computed
// expectations; a shortened segment length keeps the long runs affordable.
module tb_user_logic_signal_processing;

   localparam int SEG = 208;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic [15:0]   x0_i = '0, x0z_i = '0, x1_i = '0, x1z_i = '0;
   logic [3:0]    trigger_vector_i = '0;
   logic [127:0]  user_register_i = '0;
   logic [15:0]   y0_o, y0z_o, y1_o, y1z_o;
   logic [3:0]    trigger_vector_o;
   logic [63:0]   user_register_o;
   logic [15:0]   ul_partnum_1_o, ul_partnum_2_o, ul_partnum_3_o, ul_partnum_rev_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   user_logic_signal_processing #(.SEG_CLKS(SEG), .ACC_W(40)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .x0_i             (x0_i),
      .x0z_i            (x0z_i),
      .x1_i             (x1_i),
      .x1z_i            (x1z_i),
      .trigger_vector_i (trigger_vector_i),
      .user_register_i  (user_register_i),
      .y0_o             (y0_o),
      .y0z_o            (y0z_o),
      .y1_o             (y1_o),
      .y1z_o            (y1z_o),
      .trigger_vector_o (trigger_vector_o),
      .user_register_o  (user_register_o),
      .ul_partnum_1_o   (ul_partnum_1_o),
      .ul_partnum_2_o   (ul_partnum_2_o),
      .ul_partnum_3_o   (ul_partnum_3_o),
      .ul_partnum_rev_o (ul_partnum_rev_o)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_samples(input logic [15:0] v);
      x0_i  = v;
      x0z_i = v;
   endtask

   task automatic set_nacc(input logic [7:0] n);
      user_register_i[7:0] = n;
   endtask

   task automatic trig_pulse();
      trigger_vector_i[0] = 1'b1;
      tick(1);
      trigger_vector_i[0] = 1'b0;
   endtask

   task automatic read_bin(input string tag, input int addr, input logic [31:0] exp);
      user_register_i[40:32] = 9'(addr);
      tick(2);
      check(tag, {32'd0, user_register_o[63:32]}, {32'd0, exp});
   endtask

   task automatic check_status(input string tag, input logic [7:0] cnt, input logic busy,
                               input logic done);
      check({tag, "_count"}, {56'd0, user_register_o[23:16]}, {56'd0, cnt});
      check({tag, "_busy"},  {63'd0, user_register_o[1]},     {63'd0, busy});
      check({tag, "_done"},  {63'd0, user_register_o[0]},     {63'd0, done});
   endtask

   initial begin
      // Reset held with busy inputs: every output except partnums stays 0.
      x0_i = 16'hAAAA; x0z_i = 16'h5555; x1_i = 16'h1111; x1z_i = 16'h2222;
      trigger_vector_i = 4'b1110;
      tick(3);
      check("rst_y0",   {48'd0, y0_o},  64'd0);
      check("rst_y0z",  {48'd0, y0z_o}, 64'd0);
      check("rst_y1",   {48'd0, y1_o},  64'd0);
      check("rst_y1z",  {48'd0, y1z_o}, 64'd0);
      check("rst_trig", {60'd0, trigger_vector_o}, 64'd0);
      check("rst_ureg", user_register_o, 64'd0);
      check("partnum1", {48'd0, ul_partnum_1_o},   64'h0214);
      check("partnum2", {48'd0, ul_partnum_2_o},   64'h5350);
      check("partnum3", {48'd0, ul_partnum_3_o},   64'h4543);
      check("partrev",  {48'd0, ul_partnum_rev_o}, 64'h0001);

      x0_i = '0; x0z_i = '0; x1_i = '0; x1z_i = '0; trigger_vector_i = '0;
      rst_i = 1'b1;
      tick(2);

      // Pass-through: nothing before the edge, exact copy one clock later.
      x0_i = 16'h1234; x1z_i = 16'h8000; trigger_vector_i = 4'b1000;
      check("pt_y0_before", {48'd0, y0_o}, 64'd0);
      tick(1);
      check("pt_y0",   {48'd0, y0_o},  64'h1234);
      check("pt_y1z",  {48'd0, y1z_o}, 64'h8000);
      check("pt_trig", {60'd0, trigger_vector_o}, 64'h8);
      check("pt_y0z",  {48'd0, y0z_o}, 64'd0);
      trigger_vector_i = '0;
      tick(2);

      // Second trigger while busy is ignored; p = 10^2 + 10^2 = 200.
      set_samples(16'd10);
      set_nacc(8'd2);
      trig_pulse();
      check_status("ign_busy", 8'd0, 1'b1, 1'b0);
      tick(99);
      trig_pulse();
      tick(SEG);
      check_status("ign_after", 8'd1, 1'b0, 1'b0);
      read_bin("ign_bin0", 0, 32'd200);
      read_bin("ign_binlast", SEG - 1, 32'd200);
      trig_pulse();
      tick(100);
      read_bin("mid_bin0", 0, 32'd400);
      read_bin("mid_binlast", SEG - 1, 32'd200);
      tick(SEG);
      check_status("nacc2_end", 8'd2, 1'b0, 1'b1);
      read_bin("nacc2_binlast", SEG - 1, 32'd400);

      // 16 pulses of p = 20000 -> 320000 in every bin; fresh run after done.
      set_samples(16'd100);
      set_nacc(8'd16);
      for (int i = 0; i < 16; i++) begin
         trig_pulse();
         tick(599);
      end
      check_status("acc16", 8'd16, 1'b0, 1'b1);
      for (int b = 0; b < SEG; b++) read_bin("acc16_bin", b, 32'd320000);

      // Full-scale negative samples: p = 2^31, saturates from the second pulse on.
      set_samples(16'h8000);
      set_nacc(8'd255);
      trig_pulse();
      tick(SEG + 5);
      check_status("sat_first", 8'd1, 1'b0, 1'b0);
      read_bin("sat_first_bin", 5, 32'h8000_0000);
      for (int i = 1; i < 255; i++) begin
         trig_pulse();
         tick(SEG + 5);
      end
      check_status("sat_end", 8'd255, 1'b0, 1'b1);
      read_bin("sat_bin0", 0, 32'hFFFF_FFFF);
      read_bin("sat_binlast", SEG - 1, 32'hFFFF_FFFF);

      // Reset at k=200 aborts the segment; N_ACC=0 acts as a single pulse.
      set_samples(16'd5);
      set_nacc(8'd0);
      trig_pulse();
      tick(200);
      rst_i = 1'b0;
      tick(1);
      check_status("midrst_in", 8'd0, 1'b0, 1'b0);
      rst_i = 1'b1;
      tick(SEG + 10);
      check_status("midrst_idle", 8'd0, 1'b0, 1'b0);
      set_samples(16'd3);
      trig_pulse();
      tick(SEG + 5);
      check_status("restart", 8'd1, 1'b0, 1'b1);
      read_bin("restart_bin0", 0, 32'd18);
      read_bin("restart_bin100", 100, 32'd18);
      read_bin("restart_binlast", SEG - 1, 32'd18);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
